// File: rtl/pan_digit_capture_if.sv
// Keypad-side bus for the PAN digit collector: strobes in, packed digits and status out.
interface pan_digit_capture_if #(
  parameter int MAX_DIGITS = 19
);
  logic                      digit_valid;
  logic [3:0]                digit_in;
  logic                      backspace;
  logic                      enter;
  logic                      clear;
  logic [4*MAX_DIGITS-1:0]   pan_bcd;
  logic                      pan_ready;
  logic [4:0]                digit_count;
  logic                      entry_err;

  modport master (
    output digit_valid, digit_in, backspace, enter, clear,
    input  pan_bcd, pan_ready, digit_count, entry_err
  );

  modport slave (
    input  digit_valid, digit_in, backspace, enter, clear,
    output pan_bcd, pan_ready, digit_count, entry_err
  );
endinterface

// File: rtl/pan_digit_capture.sv
// Collects BCD digits into a packed PAN bus ahead of the Luhn validator.
// Strobe priority each cycle: clear > enter > backspace > digit_valid.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | no digits stored
// S_ENTRY | 1..MAX_DIGITS digits stored, still accepting keys
// S_DONE  | exactly REQ_DIGITS committed, PAN held, wait for clear
// S_ERROR | bad key or wrong-length enter, PAN frozen, wait for clear
module pan_digit_capture #(
  parameter int MAX_DIGITS = 19,
  parameter int REQ_DIGITS = 16
) (
  input  logic                clk,
  input  logic                rst,
  pan_digit_capture_if.slave  bus
);
  localparam int         PAN_W   = 4 * MAX_DIGITS;
  localparam logic [4:0] MAX_CNT = 5'(MAX_DIGITS);
  localparam logic [4:0] REQ_CNT = 5'(REQ_DIGITS);

  typedef enum logic [1:0] {S_IDLE, S_ENTRY, S_DONE, S_ERROR} state_t;

  state_t             state_q, state_n;
  logic [PAN_W-1:0]   pan_q, pan_n;
  logic [4:0]         cnt_q, cnt_n;
  logic               ready_q, err_q;
  logic [6:0]         wr_pos, bs_pos;

  // State, digit store and status flags; status flops follow the next state so
  // they rise exactly one cycle after the strobe that causes them.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pan_q   <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      pan_q   <= pan_n;
      cnt_q   <= cnt_n;
      ready_q <= (state_n == S_DONE);
      err_q   <= (state_n == S_ERROR);
    end
  end

  // Next-state and digit-store update; only the highest-priority strobe acts.
  always_comb begin
    state_n = state_q;
    pan_n   = pan_q;
    cnt_n   = cnt_q;
    wr_pos  = {cnt_q, 2'b00};
    bs_pos  = {cnt_q - 5'd1, 2'b00};
    if (bus.clear) begin
      state_n = S_IDLE;
      pan_n   = '0;
      cnt_n   = '0;
    end else if (state_q == S_IDLE || state_q == S_ENTRY) begin
      if (bus.enter) begin
        state_n = (cnt_q == REQ_CNT) ? S_DONE : S_ERROR;
      end else if (bus.backspace) begin
        // IDLE has nothing to remove, so the count cannot underflow.
        if (state_q == S_ENTRY) begin
          cnt_n             = cnt_q - 5'd1;
          pan_n[bs_pos +: 4] = 4'd0;
          if (cnt_q == 5'd1) state_n = S_IDLE;
        end
      end else if (bus.digit_valid) begin
        if (bus.digit_in > 4'd9) begin
          state_n = S_ERROR;
        end else if (cnt_q < MAX_CNT) begin
          pan_n[wr_pos +: 4] = bus.digit_in;
          cnt_n              = cnt_q + 5'd1;
          state_n            = S_ENTRY;
        end
      end
    end
  end

  assign bus.pan_bcd     = pan_q;
  assign bus.digit_count = cnt_q;
  assign bus.pan_ready   = ready_q;
  assign bus.entry_err   = err_q;
endmodule

// File: tb/tb_pan_digit_capture.sv
// Bench for pan_digit_capture: digit-list model plus directed literal checks and random strobes.
module tb_pan_digit_capture;
  localparam int MAXD = 19;
  localparam int REQD = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  bit   chk_en = 1'b0;

  always #5 clk = ~clk;

  pan_digit_capture_if #(.MAX_DIGITS(MAXD)) bus ();

  pan_digit_capture #(.MAX_DIGITS(MAXD), .REQ_DIGITS(REQD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Model: a list of entered digits, its length and a phase (0 typing, 1 done, 2 error).
  typedef struct packed {
    logic [MAXD-1:0][3:0] dig;
    int                   cnt;
    int                   phase;
  } model_t;

  model_t m = '0;

  function automatic model_t model_next(model_t cur, logic r, logic c, logic e,
                                        logic b, logic v, logic [3:0] d);
    model_t nx = cur;
    if (r || c) begin
      nx = '0;
    end else if (cur.phase == 0) begin
      if (e)
        nx.phase = (cur.cnt == REQD) ? 1 : 2;
      else if (b) begin
        if (cur.cnt > 0) nx.cnt = cur.cnt - 1;
      end else if (v) begin
        if (d > 9) nx.phase = 2;
        else if (cur.cnt < MAXD) begin
          nx.dig[cur.cnt] = d;
          nx.cnt = cur.cnt + 1;
        end
      end
    end
    return nx;
  endfunction

  function automatic logic [75:0] model_pan(model_t cur);
    logic [75:0] p = '0;
    for (int i = 0; i < MAXD; i++)
      if (i < cur.cnt) p[4*i +: 4] = cur.dig[i];
    return p;
  endfunction

  always @(posedge clk)
    m <= model_next(m, rst, bus.clear, bus.enter, bus.backspace, bus.digit_valid, bus.digit_in);

  task automatic chk(input string name, input logic [75:0] act, input logic [75:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every cycle: DUT outputs against the model, sampled mid-cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("pan_bcd", bus.pan_bcd, model_pan(m));
      chk("digit_count", 76'(bus.digit_count), 76'(m.cnt));
      chk("pan_ready", 76'(bus.pan_ready), 76'(m.phase == 1));
      chk("entry_err", 76'(bus.entry_err), 76'(m.phase == 2));
    end
  end

  task automatic step(input logic v, input logic [3:0] d, input logic b,
                      input logic e, input logic c, input logic r);
    bus.digit_valid = v;
    bus.digit_in    = d;
    bus.backspace   = b;
    bus.enter       = e;
    bus.clear       = c;
    rst             = r;
    @(negedge clk);
    bus.digit_valid = 1'b0;
    bus.digit_in    = 4'd0;
    bus.backspace   = 1'b0;
    bus.enter       = 1'b0;
    bus.clear       = 1'b0;
    rst             = 1'b0;
  endtask

  task automatic key(input logic [3:0] d);
    step(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic status(input string tag, input logic [75:0] pan, input int cnt,
                        input logic rdy, input logic err);
    chk({tag, "_pan"}, bus.pan_bcd, pan);
    chk({tag, "_cnt"}, 76'(bus.digit_count), 76'(cnt));
    chk({tag, "_rdy"}, 76'(bus.pan_ready), 76'(rdy));
    chk({tag, "_err"}, 76'(bus.entry_err), 76'(err));
  endtask

  int t1 [16] = '{4,5,3,9,1,4,8,8,0,3,4,3,6,4,6,7};

  initial begin
    bus.digit_valid = 1'b0;
    bus.digit_in    = 4'd0;
    bus.backspace   = 1'b0;
    bus.enter       = 1'b0;
    bus.clear       = 1'b0;
    @(negedge clk);
    step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk_en = 1'b1;
    status("reset", 76'h0, 0, 1'b0, 1'b0);

    // 1: sixteen digits then enter
    foreach (t1[i]) key(4'(t1[i]));
    step(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    status("t1_done", 76'h000_7646_3430_8841_9354, 16, 1'b1, 1'b0);
    key(4'd2);
    step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    status("t1_frozen", 76'h000_7646_3430_8841_9354, 16, 1'b1, 1'b0);

    // 2: fifteen digits, enter -> error, clear -> idle
    step(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 15; i++) key(4'd1);
    step(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    status("t2_err", 76'h0000_1111_1111_1111_1111 & {16'h0, {15{4'h1}}}, 15, 1'b0, 1'b1);
    step(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    status("t2_clear", 76'h0, 0, 1'b0, 1'b0);

    // 3: backspace in the middle and back to empty
    key(4'd1); key(4'd2); key(4'd3);
    step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    key(4'd9);
    status("t3_edit", 76'h921, 3, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    status("t3_empty", 76'h0, 0, 1'b0, 1'b0);
    step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    status("t3_bs_idle", 76'h0, 0, 1'b0, 1'b0);

    // 4: overflow past nineteen digits, then wrong-length enter
    for (int i = 0; i < 20; i++) key(4'd5);
    status("t4_full", {19{4'h5}}, 19, 1'b0, 1'b0);
    step(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    status("t4_err", {19{4'h5}}, 19, 1'b0, 1'b1);
    step(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);

    // 5: non-numeric key after two digits
    key(4'd7); key(4'd8);
    key(4'hA);
    status("t5_err", 76'h87, 2, 1'b0, 1'b1);
    key(4'd3);
    status("t5_hold", 76'h87, 2, 1'b0, 1'b1);
    step(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);

    // 6: clear beats digit in DONE; reset mid-entry
    for (int i = 0; i < 16; i++) key(4'd9);
    step(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    status("t6_done", {12'h0, {16{4'h9}}}, 16, 1'b1, 1'b0);
    step(1'b1, 4'd4, 1'b0, 1'b0, 1'b1, 1'b0);
    status("t6_clear", 76'h0, 0, 1'b0, 1'b0);
    key(4'd6); key(4'd2);
    step(1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1);
    status("t6_rst", 76'h0, 0, 1'b0, 1'b0);

    // Random strobes, biased toward reaching DONE and leaving terminal states.
    for (int n = 0; n < 3000; n++) begin
      logic v, b, e, c, r;
      logic [3:0] d;
      v = ($urandom % 2) == 0;
      d = (($urandom % 10) == 0) ? 4'(10 + $urandom % 6) : 4'($urandom % 10);
      b = ($urandom % 8) == 0;
      e = (m.cnt == REQD) ? (($urandom % 3) == 0) : (($urandom % 40) == 0);
      c = (m.phase != 0) ? (($urandom % 6) == 0) : (($urandom % 80) == 0);
      r = ($urandom % 200) == 0;
      step(v, d, b, e, c, r);
    end

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
